// File: rtl/id_issue_stage.sv
// id_issue_stage
//   Registered decode/issue stage between IF/ID and EX of the MIPS32 pipeline.
//   Decodes the logic, shift and immediate-logic instructions, reads the
//   register file, forwards results from NUM_FWD write-back sources (index 0
//   is youngest and wins), stalls on a load-use hazard and holds the decoded
//   instruction in an output register with valid/ready handshakes.
//
//   Optional feature macro: ID_INVALID_TRAP_EN
//     defined   -> inst_invalid_o port exists, registered with the instruction
//     undefined -> invalid instructions issue as NOP with wreg_o = 0
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   in_valid / in_ready             IF/ID handshake (in_ready combinational)
//   pc_i, inst_i                    instruction address and word
//   rf_re1/2, rf_raddr1/2           register file read requests (combinational)
//   rf_rdata1/2                     register file read data, same cycle
//   fwd_we_i, fwd_waddr_i,
//   fwd_wdata_i, fwd_is_load_i      forwarding sources, slice k per source
//   flush_i                         discard stage contents
//   out_valid / out_ready           EX handshake
//   pc_o, aluop_o, alusel_o,
//   reg1_o, reg2_o, wd_o, wreg_o    registered decoded instruction
//   inst_invalid_o                  registered invalid flag (macro only)

module id_issue_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               pc_i,
    input  logic [31:0]               inst_i,
    output logic                      rf_re1,
    output logic                      rf_re2,
    output logic [REG_AW-1:0]         rf_raddr1,
    output logic [REG_AW-1:0]         rf_raddr2,
    input  logic [DATA_W-1:0]         rf_rdata1,
    input  logic [DATA_W-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]        fwd_we_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    input  logic [NUM_FWD-1:0]        fwd_is_load_i,
    input  logic                      flush_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               pc_o,
    output logic [7:0]                aluop_o,
    output logic [2:0]                alusel_o,
    output logic [DATA_W-1:0]         reg1_o,
    output logic [DATA_W-1:0]         reg2_o,
    output logic [REG_AW-1:0]         wd_o,
`ifdef ID_INVALID_TRAP_EN
    output logic                      inst_invalid_o,
`endif
    output logic                      wreg_o
);

    // Opcodes / function codes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_PREF    = 6'b110011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_SYNC = 6'b001111;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;

    // ALU operations and result selects
    localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP  = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP = 8'b00000011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    localparam logic [REG_AW-1:0] NOP_REG_ADDR = '0;

    // Instruction fields
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm16;

    assign op    = inst_i[31:26];
    assign rs    = inst_i[25:21];
    assign rt    = inst_i[20:16];
    assign rd    = inst_i[15:11];
    assign sa    = inst_i[10:6];
    assign fn    = inst_i[5:0];
    assign imm16 = inst_i[15:0];

    // Decode results
    logic [7:0]        dec_aluop;
    logic [2:0]        dec_alusel;
    logic [REG_AW-1:0] dec_wd;
    logic              dec_wreg;
    logic              dec_re1, dec_re2;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_invalid;

    always_comb begin
        dec_aluop   = EXE_NOP_OP;
        dec_alusel  = EXE_RES_NOP;
        dec_wd      = NOP_REG_ADDR;
        dec_wreg    = 1'b0;
        dec_re1     = 1'b0;
        dec_re2     = 1'b0;
        dec_imm     = '0;
        dec_invalid = 1'b1;
        case (op)
            OP_SPECIAL: begin
                if (sa == 5'd0) begin
                    case (fn)
                        FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                            dec_re1     = 1'b1;
                            dec_re2     = 1'b1;
                            dec_wd      = REG_AW'(rd);
                            dec_wreg    = 1'b1;
                            dec_alusel  = EXE_RES_LOGIC;
                            dec_invalid = 1'b0;
                            case (fn)
                                FN_AND:  dec_aluop = EXE_AND_OP;
                                FN_OR:   dec_aluop = EXE_OR_OP;
                                FN_XOR:  dec_aluop = EXE_XOR_OP;
                                default: dec_aluop = EXE_NOR_OP;
                            endcase
                        end
                        FN_SLLV, FN_SRLV, FN_SRAV: begin
                            dec_re1     = 1'b1;
                            dec_re2     = 1'b1;
                            dec_wd      = REG_AW'(rd);
                            dec_wreg    = 1'b1;
                            dec_alusel  = EXE_RES_SHIFT;
                            dec_invalid = 1'b0;
                            case (fn)
                                FN_SLLV: dec_aluop = EXE_SLL_OP;
                                FN_SRLV: dec_aluop = EXE_SRL_OP;
                                default: dec_aluop = EXE_SRA_OP;
                            endcase
                        end
                        FN_SYNC: dec_invalid = 1'b0;
                        default: ;
                    endcase
                end
                // Shift by immediate: inst[31:21] all zero, sa goes to operand 1.
                if (rs == 5'd0) begin
                    case (fn)
                        FN_SLL, FN_SRL, FN_SRA: begin
                            dec_re2     = 1'b1;
                            dec_imm     = DATA_W'(sa);
                            dec_wd      = REG_AW'(rd);
                            dec_wreg    = 1'b1;
                            dec_alusel  = EXE_RES_SHIFT;
                            dec_invalid = 1'b0;
                            case (fn)
                                FN_SLL:  dec_aluop = EXE_SLL_OP;
                                FN_SRL:  dec_aluop = EXE_SRL_OP;
                                default: dec_aluop = EXE_SRA_OP;
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec_re1     = 1'b1;
                dec_imm     = DATA_W'({16'h0000, imm16});
                dec_wd      = REG_AW'(rt);
                dec_wreg    = 1'b1;
                dec_alusel  = EXE_RES_LOGIC;
                dec_invalid = 1'b0;
                case (op)
                    OP_ANDI: dec_aluop = EXE_AND_OP;
                    OP_ORI:  dec_aluop = EXE_OR_OP;
                    default: dec_aluop = EXE_XOR_OP;
                endcase
            end
            OP_LUI: begin
                dec_re1     = 1'b1;
                dec_imm     = DATA_W'({imm16, 16'h0000});
                dec_aluop   = EXE_OR_OP;
                dec_wd      = REG_AW'(rt);
                dec_wreg    = 1'b1;
                dec_alusel  = EXE_RES_LOGIC;
                dec_invalid = 1'b0;
            end
            OP_PREF: dec_invalid = 1'b0;
            default: ;
        endcase
    end

    // Register file requests
    assign rf_re1    = dec_re1 & ~rst;
    assign rf_re2    = dec_re2 & ~rst;
    assign rf_raddr1 = REG_AW'(rs);
    assign rf_raddr2 = REG_AW'(rt);

    // Returns {hit, is_load, data} of the lowest-index matching source.
    function automatic logic [DATA_W+1:0] fwd_pick(input logic [REG_AW-1:0] addr);
        logic [DATA_W+1:0] sel;
        sel = '0;
        for (int unsigned k = 0; k < NUM_FWD; k++) begin
            if (!sel[DATA_W+1] && fwd_we_i[k] &&
                (fwd_waddr_i[k*REG_AW +: REG_AW] == addr))
                sel = {1'b1, fwd_is_load_i[k], fwd_wdata_i[k*DATA_W +: DATA_W]};
        end
        return sel;
    endfunction

    logic              hit1, hit2, load1, load2;
    logic [DATA_W-1:0] fdata1, fdata2;
    logic [DATA_W-1:0] opnd1, opnd2;
    logic              hazard;

    always_comb begin
        {hit1, load1, fdata1} = fwd_pick(rf_raddr1);
        {hit2, load2, fdata2} = fwd_pick(rf_raddr2);

        if (!dec_re1)              opnd1 = dec_imm;
        else if (rf_raddr1 == '0)  opnd1 = '0;
        else if (hit1)             opnd1 = fdata1;
        else                       opnd1 = rf_rdata1;

        if (!dec_re2)              opnd2 = dec_imm;
        else if (rf_raddr2 == '0)  opnd2 = '0;
        else if (hit2)             opnd2 = fdata2;
        else                       opnd2 = rf_rdata2;

        // Only the winning source matters: a younger non-load match shadows an older load.
        hazard = in_valid &
                 ((rf_re1 & (rf_raddr1 != '0) & hit1 & load1) |
                  (rf_re2 & (rf_raddr2 != '0) & hit2 & load2));
    end

    logic accept;
    logic wreg_d;

    assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush_i;
    assign accept   = in_valid & in_ready;
    assign wreg_d   = dec_wreg & ~dec_invalid;

    // Output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            pc_o           <= '0;
            aluop_o        <= EXE_NOP_OP;
            alusel_o       <= EXE_RES_NOP;
            reg1_o         <= '0;
            reg2_o         <= '0;
            wd_o           <= NOP_REG_ADDR;
            wreg_o         <= 1'b0;
`ifdef ID_INVALID_TRAP_EN
            inst_invalid_o <= 1'b0;
`endif
        end else begin
            if (flush_i)
                out_valid <= 1'b0;
            else if (accept)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;

            if (accept) begin
                pc_o           <= pc_i;
                aluop_o        <= dec_aluop;
                alusel_o       <= dec_alusel;
                reg1_o         <= opnd1;
                reg2_o         <= opnd2;
                wd_o           <= dec_wd;
                wreg_o         <= wreg_d;
`ifdef ID_INVALID_TRAP_EN
                inst_invalid_o <= dec_invalid;
`endif
            end
        end
    end

endmodule

// File: tb/tb_id_issue_stage.sv
module tb_id_issue_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NF = 2;

`ifdef ID_INVALID_TRAP_EN
    localparam logic INV_EXP = 1'b1;
`else
    localparam logic INV_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready;
    logic [31:0]       pc_i, inst_i;
    logic              rf_re1, rf_re2;
    logic [AW-1:0]     rf_raddr1, rf_raddr2;
    logic [DW-1:0]     rf_rdata1, rf_rdata2;
    logic [NF-1:0]     fwd_we_i, fwd_is_load_i;
    logic [NF*AW-1:0]  fwd_waddr_i;
    logic [NF*DW-1:0]  fwd_wdata_i;
    logic              flush_i;
    logic              out_valid, out_ready;
    logic [31:0]       pc_o;
    logic [7:0]        aluop_o;
    logic [2:0]        alusel_o;
    logic [DW-1:0]     reg1_o, reg2_o;
    logic [AW-1:0]     wd_o;
    logic              wreg_o;
`ifdef ID_INVALID_TRAP_EN
    logic              inst_invalid_o;
`endif

    always #5 clk = ~clk;

    id_issue_stage #(.DATA_W(DW), .REG_AW(AW), .NUM_FWD(NF)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .inst_i(inst_i),
        .rf_re1(rf_re1), .rf_re2(rf_re2),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i),
        .fwd_wdata_i(fwd_wdata_i), .fwd_is_load_i(fwd_is_load_i),
        .flush_i(flush_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
        .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o),
`ifdef ID_INVALID_TRAP_EN
        .inst_invalid_o(inst_invalid_o),
`endif
        .wreg_o(wreg_o)
    );

    // Register file model: $i = 0xA000_0000 | i, $2 = 0x0F, $0 deliberately nonzero.
    logic [31:0] rf_mem [32];
    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic        inv;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    function automatic exp_t mk(input logic [31:0] pc, input logic [7:0] op,
                                input logic [2:0] sel, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [4:0] wd,
                                input logic wreg, input logic inv);
        exp_t e;
        e.pc = pc; e.aluop = op; e.alusel = sel; e.r1 = r1; e.r2 = r2;
        e.wd = wd; e.wreg = wreg; e.inv = inv;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every EX transfer is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got pc_o %h, expected no output", pc_o);
            end else begin
                mon_e = sb.pop_front();
                chk("pc_o",     pc_o,     mon_e.pc);
                chk("aluop_o",  {24'h0, aluop_o},  {24'h0, mon_e.aluop});
                chk("alusel_o", {29'h0, alusel_o}, {29'h0, mon_e.alusel});
                chk("reg1_o",   reg1_o,   mon_e.r1);
                chk("reg2_o",   reg2_o,   mon_e.r2);
                chk("wd_o",     {27'h0, wd_o},     {27'h0, mon_e.wd});
                chk("wreg_o",   {31'h0, wreg_o},   {31'h0, mon_e.wreg});
`ifdef ID_INVALID_TRAP_EN
                chk("inst_invalid_o", {31'h0, inst_invalid_o}, {31'h0, mon_e.inv});
`endif
            end
        end
    end

    // Present one instruction, wait (bounded) for in_ready, return after the accepting edge.
    task automatic send(input logic [31:0] pc, input logic [31:0] inst, input exp_t e,
                        input bit push, output int unsigned waits);
        pc_i = pc; inst_i = inst; in_valid = 1'b1; waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 (pc %h)", pc);
        end else if (push) begin
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_fwd();
        fwd_we_i = '0; fwd_waddr_i = '0; fwd_wdata_i = '0; fwd_is_load_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    int unsigned w;

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA000_0000 | i;
        rf_mem[0] = 32'hDEAD_BEEF;
        rf_mem[2] = 32'h0000_000F;
        rst = 1'b1; in_valid = 1'b0; pc_i = '0; inst_i = 32'h3401_1234;
        flush_i = 1'b0; out_ready = 1'b1;
        clear_fwd();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_pc_o", pc_o, 32'h0);
        chk("rst_reg1_o", reg1_o, 32'h0);
        chk("rst_reg2_o", reg2_o, 32'h0);
        chk("rst_aluop_o", {24'h0, aluop_o}, 32'h0);
        chk("rst_alusel_o", {29'h0, alusel_o}, 32'h0);
        chk("rst_wd_o", {27'h0, wd_o}, 32'h0);
        chk("rst_wreg_o", {31'h0, wreg_o}, 32'h0);
        chk("rst_rf_re1", {31'h0, rf_re1}, 32'h0);
        rst = 1'b0;
        #1;
        chk("ori_rf_re1", {31'h0, rf_re1}, 32'h1);
        chk("ori_rf_re2", {31'h0, rf_re2}, 32'h0);
        chk("ori_rf_raddr2", {27'h0, rf_raddr2}, 32'h1);

        // ORI $1,$0,0x1234
        send(32'h100, 32'h3401_1234, mk(32'h100, 8'h25, 3'd1, 32'h0, 32'h1234, 5'd1, 1'b1, 1'b0), 1, w);

        // OR $3,$1,$2: both sources write $1, source 0 wins
        fwd_we_i = 2'b11; fwd_waddr_i = {5'd1, 5'd1};
        fwd_wdata_i = {32'h0000_5555, 32'hAAAA_0000};
        send(32'h104, 32'h0022_1825, mk(32'h104, 8'h25, 3'd1, 32'hAAAA_0000, 32'h0F, 5'd3, 1'b1, 1'b0), 1, w);
        chk("thru_or_fwd", w, 0);

        // OR $3,$0,$0 with a source writing $0
        fwd_we_i = 2'b01; fwd_waddr_i = {5'd0, 5'd0}; fwd_wdata_i = {32'h0, 32'hFFFF_FFFF};
        send(32'h108, 32'h0000_1825, mk(32'h108, 8'h25, 3'd1, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0), 1, w);
        chk("thru_or_zero", w, 0);
        clear_fwd();

        // ANDI $7,$8,0xFF00
        send(32'h10C, 32'h3107_FF00, mk(32'h10C, 8'h24, 3'd1, 32'hA000_0008, 32'h0000_FF00, 5'd7, 1'b1, 1'b0), 1, w);
        chk("thru_andi", w, 0);
        // LUI $9,0xBEEF
        send(32'h110, 32'h3C09_BEEF, mk(32'h110, 8'h25, 3'd1, 32'h0, 32'hBEEF_0000, 5'd9, 1'b1, 1'b0), 1, w);
        // XORI $10,$3,0x00F0
        send(32'h114, 32'h386A_00F0, mk(32'h114, 8'h26, 3'd1, 32'hA000_0003, 32'h0000_00F0, 5'd10, 1'b1, 1'b0), 1, w);
        // NOR $11,$4,$5
        send(32'h118, 32'h0085_5827, mk(32'h118, 8'h27, 3'd1, 32'hA000_0004, 32'hA000_0005, 5'd11, 1'b1, 1'b0), 1, w);
        // SRAV rd=12, rs=6, rt=13
        send(32'h11C, 32'h00CD_6007, mk(32'h11C, 8'h03, 3'd2, 32'hA000_0006, 32'hA000_000D, 5'd12, 1'b1, 1'b0), 1, w);
        // SYNC
        send(32'h120, 32'h0000_000F, mk(32'h120, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0), 1, w);
        // Invalid opcode
        send(32'h124, 32'hFC00_0000, mk(32'h124, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, INV_EXP), 1, w);
        chk("thru_invalid", w, 0);

        // Load-use: ORI ahead, then AND $5,$2,$2 while source 0 is a load of $2
        send(32'h200, 32'h3401_1234, mk(32'h200, 8'h25, 3'd1, 32'h0, 32'h1234, 5'd1, 1'b1, 1'b0), 1, w);
        pc_i = 32'h204; inst_i = 32'h0042_2824; in_valid = 1'b1;
        fwd_we_i = 2'b01; fwd_waddr_i = {5'd0, 5'd2}; fwd_wdata_i = {32'h0, 32'h1234_5678};
        fwd_is_load_i = 2'b01;
        @(negedge clk);
        chk("lu_stall_in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        // Loaded data now from source 1; source 0 is an unrelated load ($9)
        fwd_we_i = 2'b11; fwd_waddr_i = {5'd2, 5'd9};
        fwd_wdata_i = {32'h0000_0077, 32'h0000_0BAD}; fwd_is_load_i = 2'b01;
        @(negedge clk);
        chk("lu_bubble_out_valid", {31'h0, out_valid}, 32'h0);
        chk("lu_resume_in_ready", {31'h0, in_ready}, 32'h1);
        if (in_ready) sb.push_back(mk(32'h204, 8'h24, 3'd1, 32'h77, 32'h77, 5'd5, 1'b1, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear_fwd();

        // SLL $4,$2,5 then EX back-pressure for 3 cycles
        send(32'h300, 32'h0002_2140, mk(32'h300, 8'h7C, 3'd2, 32'h5, 32'h0F, 5'd4, 1'b1, 1'b0), 1, w);
        out_ready = 1'b0;
        pc_i = 32'h304; inst_i = 32'h3401_1234; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold_out_valid", {31'h0, out_valid}, 32'h1);
            chk("hold_reg1_o", reg1_o, 32'h5);
            chk("hold_pc_o", pc_o, 32'h300);
            chk("hold_aluop_o", {24'h0, aluop_o}, 32'h7C);
            chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(32'h304, 32'h3401_1234, mk(32'h304, 8'h25, 3'd1, 32'h0, 32'h1234, 5'd1, 1'b1, 1'b0), 1, w);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Invalid opcode held in the output register, then flush with a hazard present
        out_ready = 1'b0;
        send(32'h400, 32'hFC00_0000, mk(32'h0, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0), 0, w);
        pc_i = 32'h404; inst_i = 32'h0022_1825; in_valid = 1'b1;
        fwd_we_i = 2'b01; fwd_waddr_i = {5'd0, 5'd1}; fwd_is_load_i = 2'b01;
        flush_i = 1'b1;
        @(negedge clk);
        chk("inv_out_valid", {31'h0, out_valid}, 32'h1);
        chk("inv_wreg_o", {31'h0, wreg_o}, 32'h0);
`ifdef ID_INVALID_TRAP_EN
        chk("inv_inst_invalid_o", {31'h0, inst_invalid_o}, 32'h1);
`endif
        chk("flush_in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        flush_i = 1'b0; in_valid = 1'b0;
        clear_fwd();
        @(negedge clk);
        chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
        @(posedge clk); #1;

        // Reset asserted mid-stall
        send(32'h500, 32'h3401_1234, mk(32'h0, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0), 0, w);
        pc_i = 32'h504; inst_i = 32'h0042_2824; in_valid = 1'b1;
        fwd_we_i = 2'b01; fwd_waddr_i = {5'd0, 5'd2}; fwd_is_load_i = 2'b01;
        @(negedge clk);
        chk("rs_stall_in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rs_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rs_pc_o", pc_o, 32'h0);
        chk("rs_reg1_o", reg1_o, 32'h0);
        chk("rs_reg2_o", reg2_o, 32'h0);
        chk("rs_wd_o", {27'h0, wd_o}, 32'h0);
        chk("rs_wreg_o", {31'h0, wreg_o}, 32'h0);
        chk("rs_aluop_o", {24'h0, aluop_o}, 32'h0);
        chk("rs_rf_re1", {31'h0, rf_re1}, 32'h0);
        chk("rs_rf_re2", {31'h0, rf_re2}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        clear_fwd();

        // Recovery after reset
        send(32'h600, 32'h3401_1234, mk(32'h600, 8'h25, 3'd1, 32'h0, 32'h1234, 5'd1, 1'b1, 1'b0), 1, w);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
